// File: rtl/execute_cycle_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
// slave is the execute stage itself; master is whoever drives it.
interface execute_cycle_if #(
    parameter int XLEN = 32
);
    logic            RegWriteE;
    logic            ALUSrcE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [4:0]      RD_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ResultW;
    logic [1:0]      ForwardA_E;
    logic [1:0]      ForwardB_E;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
               ForwardA_E, ForwardB_E,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ResultW,
               ForwardA_E, ForwardB_E,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// RISC-V execute stage: operand forwarding, ALU, beq resolution and the
// EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    execute_cycle_if.slave  ex
);
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        src_a = ex.RD1_E;
        fwd_b = ex.RD2_E;
        // Select 10 reads the registered result, i.e. the previous instruction's.
        unique case (ex.ForwardA_E)
            2'b01:   src_a = ex.ResultW;
            2'b10:   src_a = ex.ALUResultM;
            default: src_a = ex.RD1_E;
        endcase
        unique case (ex.ForwardB_E)
            2'b01:   fwd_b = ex.ResultW;
            2'b10:   fwd_b = ex.ALUResultM;
            default: fwd_b = ex.RD2_E;
        endcase
        src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_b;
    end

    always_comb begin
        alu_result = '0;
        case (ex.ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = XLEN'($signed(src_a) < $signed(src_b));
            default: alu_result = '0;
        endcase
    end

    // Only beq is supported; an undefined op code yields 0 and so reads as equal.
    assign ex.PCSrcE    = ex.BranchE & (alu_result == '0);
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex.RegWriteM  <= 1'b0;
            ex.MemWriteM  <= 1'b0;
            ex.ResultSrcM <= 1'b0;
            ex.RD_M       <= '0;
            ex.ALUResultM <= '0;
            ex.WriteDataM <= '0;
            ex.PCPlus4M   <= '0;
        end else begin
            ex.RegWriteM  <= ex.RegWriteE;
            ex.MemWriteM  <= ex.MemWriteE;
            ex.ResultSrcM <= ex.ResultSrcE;
            ex.RD_M       <= ex.RD_E;
            ex.ALUResultM <= alu_result;
            ex.WriteDataM <= fwd_b;
            ex.PCPlus4M   <= ex.PCPlus4E;
        end
    end
endmodule
